// File: rtl/mic1_run_control.sv
// mic1_run_control: run/step/stop controller for the mic1_soc board top-levels.
// Each button goes through a 2-FF synchroniser, a debouncer and a rising-edge
// detector. Step bursts enable the core for step_count cycles.
// Optional feature macro: MIC1_BREAKPOINT_EN adds the PC breakpoint halt
// (BREAK state, bp_mask). Without it the breakpoint inputs are ignored.

module mic1_btn_cond #(
    parameter int DEBOUNCE_MAX = 511
) (
    input  logic clk,
    input  logic resetn,
    input  logic i_btn,
    output logic o_level,
    output logic o_rise
);
    localparam int CW = (DEBOUNCE_MAX > 0) ? $clog2(DEBOUNCE_MAX + 1) : 1;

    logic          r_sync1, r_sync2;
    logic          r_db, r_db_prev;
    logic [CW-1:0] r_cnt;

    // Synchronise, then only accept a new level after DEBOUNCE_MAX+1 equal samples.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_db      <= 1'b0;
            r_db_prev <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync1   <= i_btn;
            r_sync2   <= r_sync1;
            r_db_prev <= r_db;
            if (r_sync2 == r_db) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(DEBOUNCE_MAX)) begin
                r_db  <= r_sync2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_level = r_db;
    assign o_rise  = r_db & ~r_db_prev;
endmodule

module mic1_run_control #(
    parameter int DEBOUNCE_MAX = 511,
    parameter int STEP_W       = 8,
    parameter int ADDR_W       = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_btn_run,
    input  logic              i_btn_step,
    input  logic              i_btn_stop,
    input  logic [STEP_W-1:0] i_step_count,
    input  logic [ADDR_W-1:0] i_pc,
    input  logic              i_pc_valid,
    input  logic [ADDR_W-1:0] i_bp_addr,
    input  logic              i_bp_en,
    output logic              o_run,
    output logic [1:0]        o_state,
    output logic              o_led_idle,
    output logic              o_led_run,
    output logic              o_led_break,
    output logic [STEP_W-1:0] o_steps_left
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_STEP  = 2'd2,
        S_BREAK = 2'd3
    } state_t;

    state_t            r_state, w_next;
    logic [STEP_W-1:0] r_cnt, w_cnt_next, w_load;
    logic              r_run, r_led_idle, r_led_run;
    logic              w_run_e, w_step_e, w_stop, w_bp_hit;
    logic              w_run_lvl_unused, w_step_lvl_unused, w_stop_rise_unused;

    mic1_btn_cond #(.DEBOUNCE_MAX(DEBOUNCE_MAX)) u_run (
        .clk(clk), .resetn(resetn), .i_btn(i_btn_run),
        .o_level(w_run_lvl_unused), .o_rise(w_run_e));
    mic1_btn_cond #(.DEBOUNCE_MAX(DEBOUNCE_MAX)) u_step (
        .clk(clk), .resetn(resetn), .i_btn(i_btn_step),
        .o_level(w_step_lvl_unused), .o_rise(w_step_e));
    mic1_btn_cond #(.DEBOUNCE_MAX(DEBOUNCE_MAX)) u_stop (
        .clk(clk), .resetn(resetn), .i_btn(i_btn_stop),
        .o_level(w_stop), .o_rise(w_stop_rise_unused));

    // A zero step_count still gives a single-cycle burst.
    assign w_load = (i_step_count == '0) ? STEP_W'(1) : i_step_count;

`ifdef MIC1_BREAKPOINT_EN
    logic r_bp_mask, r_led_break;

    assign w_bp_hit = i_bp_en & i_pc_valid & (i_pc == i_bp_addr) & ~r_bp_mask;

    // Mask the breakpoint after resuming so the core can move off that address.
    always_ff @(posedge clk) begin
        if (!resetn)
            r_bp_mask <= 1'b0;
        else if (r_state == S_BREAK && (w_next == S_RUN || w_next == S_STEP))
            r_bp_mask <= 1'b1;
        else if (i_pc_valid && i_pc != i_bp_addr)
            r_bp_mask <= 1'b0;
    end

    // Break LED registered alongside the other status outputs.
    always_ff @(posedge clk) begin
        if (!resetn) r_led_break <= 1'b0;
        else         r_led_break <= (w_next == S_BREAK);
    end

    assign o_led_break = r_led_break;
`else
    logic w_bp_unused;
    assign w_bp_unused = ^{i_pc, i_pc_valid, i_bp_addr, i_bp_en};
    assign w_bp_hit    = 1'b0;
    assign o_led_break = 1'b0;
`endif

    // Next-state and burst counter; stop beats breakpoint beats run beats step.
    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        case (r_state)
            S_IDLE: begin
                w_cnt_next = '0;
                if (!w_stop) begin
                    if (w_run_e) begin
                        w_next = S_RUN;
                    end else if (w_step_e) begin
                        w_next     = S_STEP;
                        w_cnt_next = w_load;
                    end
                end
            end
            S_RUN: begin
                if (w_stop)        w_next = S_IDLE;
                else if (w_bp_hit) w_next = S_BREAK;
            end
            S_STEP: begin
                if (w_stop || w_bp_hit || r_cnt <= STEP_W'(1)) begin
                    w_next     = w_stop ? S_IDLE : (w_bp_hit ? S_BREAK : S_IDLE);
                    w_cnt_next = '0;
                end else begin
                    w_cnt_next = r_cnt - STEP_W'(1);
                end
            end
            S_BREAK: begin
                if (w_stop) begin
                    w_next = S_IDLE;
                end else if (w_run_e) begin
                    w_next = S_RUN;
                end else if (w_step_e) begin
                    w_next     = S_STEP;
                    w_cnt_next = w_load;
                end
            end
            default: begin
                w_next     = S_IDLE;
                w_cnt_next = '0;
            end
        endcase
    end

    // State, counter and status outputs all update on the same edge.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_run      <= 1'b0;
            r_led_idle <= 1'b1;
            r_led_run  <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_cnt      <= w_cnt_next;
            r_run      <= (w_next == S_RUN) || (w_next == S_STEP);
            r_led_idle <= (w_next == S_IDLE);
            r_led_run  <= (w_next == S_RUN) || (w_next == S_STEP);
        end
    end

    assign o_run        = r_run;
    assign o_state      = r_state;
    assign o_led_idle   = r_led_idle;
    assign o_led_run    = r_led_run;
    assign o_steps_left = r_cnt;
endmodule

// File: tb/tb_mic1_run_control.sv
// Directed bench for mic1_run_control with DEBOUNCE_MAX=3.
// A press becomes visible on the outputs 7 clock edges after it is driven.
`timescale 1ns/1ps
module tb_mic1_run_control;
    logic        clk = 1'b0;
    logic        resetn;
    logic        btn_run, btn_step, btn_stop;
    logic [7:0]  step_count;
    logic [31:0] pc, bp_addr;
    logic        pc_valid, bp_en;
    logic        run, led_idle, led_run, led_break;
    logic [1:0]  state;
    logic [7:0]  steps_left;

    int n_tests = 0;
    int n_fail  = 0;
    logic       runs [1:20];
    logic [7:0] sls  [1:20];

    mic1_run_control #(.DEBOUNCE_MAX(3), .STEP_W(8), .ADDR_W(32)) dut (
        .clk(clk), .resetn(resetn),
        .i_btn_run(btn_run), .i_btn_step(btn_step), .i_btn_stop(btn_stop),
        .i_step_count(step_count), .i_pc(pc), .i_pc_valid(pc_valid),
        .i_bp_addr(bp_addr), .i_bp_en(bp_en),
        .o_run(run), .o_state(state), .o_led_idle(led_idle),
        .o_led_run(led_run), .o_led_break(led_break), .o_steps_left(steps_left));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Record run/steps_left for 20 cycles of a step press held for 10 cycles.
    task automatic step_burst();
        btn_step = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick(1);
            runs[i] = run;
            sls[i]  = steps_left;
            if (i == 10) btn_step = 1'b0;
        end
    endtask

    task automatic press_run();
        btn_run = 1'b1; tick(8);
        btn_run = 1'b0; tick(10);
    endtask

    task automatic pc_strobe(input logic [31:0] a);
        pc = a; pc_valid = 1'b1; tick(1);
        pc_valid = 1'b0;
    endtask

    initial begin
        resetn = 1'b0; btn_run = 0; btn_step = 0; btn_stop = 0;
        step_count = 8'd0; pc = 0; pc_valid = 0; bp_addr = 32'h10; bp_en = 1'b1;
        #1;
        // 1: reset values, then a 3-cycle step glitch
        tick(2);
        chk("rst_state", state, 0);
        chk("rst_run", run, 0);
        chk("rst_led_idle", led_idle, 1);
        chk("rst_led_run", led_run, 0);
        chk("rst_led_break", led_break, 0);
        chk("rst_steps", steps_left, 0);
        resetn = 1'b1;
        btn_step = 1'b1; tick(3);
        btn_step = 1'b0; tick(10);
        chk("glitch_state", state, 0);
        chk("glitch_run", run, 0);

        // 2: five-cycle burst, then zero-count burst
        step_count = 8'd5;
        step_burst();
        for (int i = 1; i <= 20; i++) begin
            if (i >= 7 && i <= 11) begin
                chk("step5_run", runs[i], 1);
                chk("step5_left", sls[i], 32'(12 - i));
            end else begin
                chk("step5_idle_run", runs[i], 0);
            end
        end
        chk("step5_end_state", state, 0);
        chk("step5_end_led_idle", led_idle, 1);
        step_count = 8'd0;
        step_burst();
        for (int i = 1; i <= 20; i++) begin
            chk("step0_run", runs[i], (i == 7) ? 1 : 0);
            if (i == 7) chk("step0_left", sls[i], 1);
        end

        // 3: run, repeated run press, stop
        press_run();
        chk("run_state", state, 1);
        chk("run_run", run, 1);
        chk("run_led_run", led_run, 1);
        chk("run_led_idle", led_idle, 0);
        press_run();
        chk("run_again_state", state, 1);
        btn_stop = 1'b1;
        tick(6);
        chk("stop_pre_run", run, 1);
        btn_stop = 1'b0;
        tick(1);
        chk("stop_run", run, 0);
        chk("stop_state", state, 0);
        tick(10);

        // 4: run and stop together from IDLE
        btn_run = 1'b1; btn_stop = 1'b1;
        for (int i = 0; i < 18; i++) begin
            tick(1);
            if (i == 8) begin btn_run = 1'b0; btn_stop = 1'b0; end
            if (run) chk("both_run", run, 0);
        end
        chk("both_state", state, 0);

        // 5: breakpoint halt and resume
        press_run();
        chk("bp_run_state", state, 1);
        pc_strobe(32'h10);
`ifdef MIC1_BREAKPOINT_EN
        chk("bp_hit_state", state, 3);
        chk("bp_hit_run", run, 0);
        chk("bp_hit_led_break", led_break, 1);
        chk("bp_hit_led_run", led_run, 0);
        press_run();
        chk("bp_resume_state", state, 1);
        pc_strobe(32'h10);
        chk("bp_masked_state", state, 1);
        pc_strobe(32'h14);
        chk("bp_moved_state", state, 1);
        pc_strobe(32'h10);
        chk("bp_rehit_state", state, 3);
        chk("bp_rehit_run", run, 0);
`else
        chk("nobp_state", state, 1);
        chk("nobp_led_break", led_break, 0);
`endif
        btn_stop = 1'b1; tick(8);
        btn_stop = 1'b0; tick(10);
        chk("bp_stop_state", state, 0);
        chk("bp_stop_led_break", led_break, 0);

        // 6: reset mid-burst
        step_count = 8'd5;
        btn_step = 1'b1;
        tick(9);
        chk("mid_left", steps_left, 3);
        chk("mid_state", state, 2);
        resetn = 1'b0; btn_step = 1'b0;
        tick(1);
        chk("abort_state", state, 0);
        chk("abort_run", run, 0);
        chk("abort_left", steps_left, 0);
        chk("abort_led_idle", led_idle, 1);
        resetn = 1'b1;
        tick(12);
        chk("after_abort_state", state, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
